// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, next-PC selection and
// a three-state handshake around the registered instruction memory.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_AW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_req,
  input  logic             pc_update,
  input  logic [1:0]       npc_sel,
  input  logic [15:0]      imm16,
  input  logic [25:0]      jump_target,
  input  logic [31:0]      jr_target,
  input  logic [31:0]      im_dout,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_done,
  output logic             misalign_err,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] npc;
  logic [31:0] br_off;
  logic        idle;

  assign idle     = (state == IDLE);
  assign pc_plus4 = pc + 32'd4;
  assign im_addr  = pc[IM_AW+1:2];
  assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    npc = pc_plus4;
    unique case (npc_sel)
      2'b00: npc = pc_plus4;
      2'b01: npc = pc_plus4 + br_off;
      2'b10: npc = {pc_plus4[31:28], jump_target, 2'b00};
      2'b11: npc = {jr_target[31:2], 2'b00};
      default: npc = pc_plus4;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (fetch_req) state_nx = READ;
      READ:    state_nx = LATCH;
      LATCH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr        <= 32'h0;
      fetch_done   <= 1'b0;
      misalign_err <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      fetch_done <= (state == LATCH);
      if (state == LATCH)
        instr <= im_dout;
      // pc only moves in IDLE so the in-flight read address stays stable
      if (pc_update && idle) begin
        pc <= npc;
        if (npc_sel == 2'b11 && jr_target[1:0] != 2'b00)
          misalign_err <= 1'b1;
      end else if (pc_update) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule
